vx_sfu_req_sched: RTL and testbench

Request scheduler and response arbiter for the SFU sub-unit cluster (warp control, CSR, and optional TEX/RASTER/ROP agents). It steers each incoming SFU request to its target sub-unit and tracks outstanding operations per sub-unit with credit counters. It enforces fence ordering for warp-control operations and merges sub-unit responses into one registered commit stream using round-robin arbitration. It sits between the SFU dispatch output and the gather unit.

---
 rtl/vx_sfu_req_sched.sv | 102 ++++++++++
 tb/tb_vx_sfu_req_sched.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_sfu_req_sched.sv
// vx_sfu_req_sched: steers SFU requests to sub-units under credit/fence control and round-robin merges their responses
module vx_sfu_req_sched #(
  parameter int NUM_UNITS   = 2,
  parameter int MAX_PENDING = 4,
  parameter int DATAW       = 64,
  parameter int UNIT_BITS   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       req_valid_i,
  input  logic [UNIT_BITS-1:0]       req_unit_i,
  input  logic                       req_fence_i,
  output logic                       req_ready_o,
  output logic [NUM_UNITS-1:0]       unit_req_valid_o,
  input  logic [NUM_UNITS-1:0]       unit_req_ready_i,
  input  logic [NUM_UNITS-1:0]       rsp_valid_in_i,
  input  logic [NUM_UNITS*DATAW-1:0] rsp_data_in_i,
  output logic [NUM_UNITS-1:0]       rsp_ready_in_o,
  output logic                       rsp_valid_out_o,
  output logic [DATAW-1:0]           rsp_data_out_o,
  output logic [UNIT_BITS-1:0]       rsp_sel_out_o,
  input  logic                       rsp_ready_out_i,
  output logic                       busy_o,
  output logic                       fence_stall_o
);
  localparam logic [1:0] IDLE = 2'd0, DRAIN = 2'd1, HOLD = 2'd2;
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NUM_UNITS];
  logic [CNT_W-1:0] cnt_d [NUM_UNITS];
  logic [NUM_UNITS-1:0] credit_v, nz_v, issue_v, grant, rsp_fire;
  logic [UNIT_BITS-1:0] fence_unit_q, last_grant_q, grant_idx, rsp_sel_q;
  logic [DATAW-1:0] rsp_data_q;
  logic rsp_valid_q, unit_ok, all_idle, fence_req, issue_en, req_fire, out_ready;
  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      credit_v[i] = cnt_q[i] < CNT_W'(MAX_PENDING);
      nz_v[i]     = cnt_q[i] != '0;
      cnt_d[i]    = (issue_v[i] == rsp_fire[i]) ? cnt_q[i] :
                    issue_v[i] ? cnt_q[i] + CNT_W'(1) :
                    nz_v[i] ? cnt_q[i] - CNT_W'(1) : cnt_q[i];
    end
  end
  assign unit_ok   = int'(req_unit_i) < NUM_UNITS;
  assign all_idle  = !(|nz_v) && !rsp_valid_q;
  assign fence_req = req_valid_i && req_fence_i;
  // A fence may only leave IDLE when nothing is outstanding anywhere, including the output register
  assign issue_en  = state_q == IDLE && (!req_fence_i || all_idle) && unit_ok && credit_v[req_unit_i];
  assign unit_req_valid_o = (req_valid_i && issue_en) ? NUM_UNITS'(1) << req_unit_i : '0;
  assign req_ready_o      = issue_en && unit_req_ready_i[req_unit_i];
  assign req_fire         = req_valid_i && req_ready_o;
  assign issue_v          = unit_req_valid_o & unit_req_ready_i;
  assign fence_stall_o    = state_q == DRAIN || (state_q == IDLE && fence_req && !all_idle);
  assign busy_o           = (|nz_v) || rsp_valid_q;
  assign state_d = state_q == DRAIN ? (all_idle ? IDLE : DRAIN) :
                   state_q == HOLD ? (rsp_fire[fence_unit_q] ? IDLE : HOLD) :
                   (fence_req && unit_ok) ? (!all_idle ? DRAIN : req_fire ? HOLD : IDLE) : IDLE;
  // Scan from lowest to highest priority so the highest-priority requester is written last
  always_comb begin
    grant_idx = last_grant_q;
    for (int k = NUM_UNITS - 1; k >= 0; k--)
      if (rsp_valid_in_i[(int'(last_grant_q) + 1 + k) % NUM_UNITS])
        grant_idx = UNIT_BITS'((int'(last_grant_q) + 1 + k) % NUM_UNITS);
  end
  assign grant           = (|rsp_valid_in_i) ? NUM_UNITS'(1) << grant_idx : '0;
  assign out_ready       = !rsp_valid_q || rsp_ready_out_i;
  assign rsp_ready_in_o  = out_ready ? grant : '0;
  assign rsp_fire        = rsp_valid_in_i & rsp_ready_in_o;
  assign rsp_valid_out_o = rsp_valid_q;
  assign rsp_data_out_o  = rsp_data_q;
  assign rsp_sel_out_o   = rsp_sel_q;
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_UNITS; i++)
      cnt_q[i] <= reset_i ? '0 : cnt_d[i];
    if (reset_i) begin
      state_q      <= IDLE;
      fence_unit_q <= '0;
      last_grant_q <= UNIT_BITS'(NUM_UNITS - 1);
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_sel_q    <= '0;
    end else begin
      state_q <= state_d;
      if (req_fire && req_fence_i)
        fence_unit_q <= req_unit_i;
      if (|rsp_fire) begin
        last_grant_q <= grant_idx;
        rsp_valid_q  <= 1'b1;
        rsp_data_q   <= rsp_data_in_i[int'(grant_idx)*DATAW +: DATAW];
        rsp_sel_q    <= grant_idx;
      end else if (rsp_ready_out_i)
        rsp_valid_q <= 1'b0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(req_valid_i && !unit_ok)) else $error("req_unit out of range");
      for (int i = 0; i < NUM_UNITS; i++)
        assert (!(rsp_fire[i] && !issue_v[i] && !nz_v[i])) else $error("pending count underflow on unit %0d", i);
    end
  end
endmodule

// File: tb/tb_vx_sfu_req_sched.sv
// tb_vx_sfu_req_sched: directed bench with a response scoreboard for vx_sfu_req_sched
module tb_vx_sfu_req_sched;
  localparam int N = 3, MP = 4, DW = 16, UB = 2;
  logic clk = 1'b0;
  logic reset, req_valid, req_fence, req_ready, rsp_valid_out, rsp_ready_out, busy, fence_stall;
  logic [UB-1:0] req_unit, rsp_sel_out;
  logic [N-1:0] unit_req_valid, unit_req_ready, rsp_valid_in, rsp_ready_in;
  logic [N*DW-1:0] rsp_data_in;
  logic [DW-1:0] rsp_data_out;
  logic [UB+DW-1:0] sb [$];
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  vx_sfu_req_sched #(.NUM_UNITS(N), .MAX_PENDING(MP), .DATAW(DW)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_unit_i(req_unit), .req_fence_i(req_fence), .req_ready_o(req_ready),
    .unit_req_valid_o(unit_req_valid), .unit_req_ready_i(unit_req_ready),
    .rsp_valid_in_i(rsp_valid_in), .rsp_data_in_i(rsp_data_in), .rsp_ready_in_o(rsp_ready_in),
    .rsp_valid_out_o(rsp_valid_out), .rsp_data_out_o(rsp_data_out), .rsp_sel_out_o(rsp_sel_out),
    .rsp_ready_out_i(rsp_ready_out), .busy_o(busy), .fence_stall_o(fence_stall)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic settle();
    #1;
  endtask
  // Record responses entering and leaving the output register, then move to the next cycle
  task automatic adv();
    logic [UB+DW-1:0] e;
    #1;
    for (int i = 0; i < N; i++)
      if (rsp_valid_in[i] && rsp_ready_in[i]) sb.push_back({UB'(i), rsp_data_in[i*DW +: DW]});
    if (rsp_valid_out && rsp_ready_out) begin
      if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
      else begin
        e = sb.pop_front();
        chk("sb_sel", rsp_sel_out, e[DW +: UB]);
        chk("sb_data", rsp_data_out, e[DW-1:0]);
      end
    end
    @(negedge clk);
  endtask
  task automatic req(input int u, input bit f);
    req_valid = 1'b1;
    req_unit  = UB'(u);
    req_fence = f;
  endtask
  task automatic set_rsp(input int u, input logic [DW-1:0] d);
    rsp_data_in[u*DW +: DW] = d;
  endtask
  task automatic issue(input int u, input int n, input string tag);
    req(u, 1'b0);
    for (int k = 0; k < n; k++) begin
      settle();
      chk(tag, req_ready, 1);
      adv();
    end
    req_valid = 1'b0;
  endtask
  task automatic drain(input int u, input int n, input logic [DW-1:0] base);
    rsp_valid_in = N'(1) << u;
    for (int k = 0; k < n; k++) begin
      set_rsp(u, base + DW'(k));
      adv();
    end
    rsp_valid_in = '0;
    adv();
  endtask
  initial begin
    reset = 1'b1; req_valid = 1'b0; req_unit = '0; req_fence = 1'b0;
    unit_req_ready = '1; rsp_valid_in = '0; rsp_data_in = '0; rsp_ready_out = 1'b1;
    @(negedge clk); @(negedge clk);
    settle();
    chk("rst_valid", rsp_valid_out, 0);
    chk("rst_sel", rsp_sel_out, 0);
    chk("rst_data", rsp_data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", fence_stall, 0);
    reset = 1'b0;
    issue(0, 2, "rr_iss0"); issue(1, 2, "rr_iss1"); issue(2, 2, "rr_iss2");
    chk("rr_busy", busy, 1);
    rsp_valid_in = '1;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) set_rsp(i, DW'(16'h1000 * c + i));
      settle();
      chk("rr_grant", rsp_ready_in, N'(1) << (c % 3));
      adv();
      chk("rr_sel", rsp_sel_out, c % 3);
    end
    rsp_valid_in = '0;
    adv();
    chk("rr_idle", busy, 0);
    req(1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("credit_rdy", req_ready, k < 4);
      chk("credit_uv", unit_req_valid, k < 4 ? 3'b010 : 3'b000);
      adv();
    end
    rsp_valid_in = 3'b010; set_rsp(1, 16'h1111);
    settle();
    chk("credit_nobypass", req_ready, 0);
    chk("credit_rspin", rsp_ready_in, 3'b010);
    adv();
    rsp_valid_in = '0;
    settle();
    chk("credit_after", req_ready, 1);
    adv();
    req_valid = 1'b0;
    drain(1, 4, 16'h1200);
    chk("credit_idle", busy, 0);
    issue(0, 2, "sim_iss");
    req(0, 1'b0); rsp_valid_in = 3'b001; set_rsp(0, 16'h00A0);
    settle();
    chk("sim_req_rdy", req_ready, 1);
    chk("sim_rsp_rdy", rsp_ready_in, 3'b001);
    adv();
    rsp_valid_in = '0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("sim_cnt", req_ready, k < 2);
      adv();
    end
    req_valid = 1'b0;
    drain(0, 4, 16'h00B0);
    chk("sim_idle", busy, 0);
    issue(0, 2, "fen_iss");
    req(1, 1'b1);
    settle();
    chk("fen_rdy0", req_ready, 0);
    chk("fen_stall0", fence_stall, 1);
    chk("fen_uv0", unit_req_valid, 0);
    adv();
    rsp_valid_in = 3'b001;
    for (int k = 0; k < 2; k++) begin
      set_rsp(0, 16'h0C00 + DW'(k));
      settle();
      chk("fen_drain_stall", fence_stall, 1);
      chk("fen_drain_rdy", req_ready, 0);
      adv();
    end
    rsp_valid_in = '0;
    settle();
    chk("fen_outreg_stall", fence_stall, 1);
    adv();
    settle();
    chk("fen_last_stall", fence_stall, 1);
    chk("fen_last_rdy", req_ready, 0);
    adv();
    settle();
    chk("fen_issue_rdy", req_ready, 1);
    chk("fen_issue_stall", fence_stall, 0);
    chk("fen_issue_uv", unit_req_valid, 3'b010);
    adv();
    req(0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("hold_block", req_ready, 0);
      chk("hold_stall", fence_stall, 0);
      adv();
    end
    rsp_valid_in = 3'b010; set_rsp(1, 16'h0C11);
    settle();
    chk("hold_block_rsp", req_ready, 0);
    adv();
    rsp_valid_in = '0;
    settle();
    chk("hold_exit", req_ready, 1);
    adv();
    req_valid = 1'b0;
    drain(0, 1, 16'h0C20);
    chk("fen_idle", busy, 0);
    issue(2, 2, "bp_iss");
    rsp_valid_in = 3'b100; set_rsp(2, 16'hDEAD);
    adv();
    rsp_ready_out = 1'b0; set_rsp(2, 16'hBEEF);
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("bp_hold_data", rsp_data_out, 16'hDEAD);
      chk("bp_hold_sel", rsp_sel_out, 2);
      chk("bp_valid", rsp_valid_out, 1);
      chk("bp_rspin", rsp_ready_in, 0);
      adv();
    end
    rsp_ready_out = 1'b1;
    settle();
    chk("bp_release", rsp_ready_in, 3'b100);
    adv();
    chk("bp_b2b_valid", rsp_valid_out, 1);
    chk("bp_b2b_data", rsp_data_out, 16'hBEEF);
    rsp_valid_in = '0;
    adv();
    chk("bp_idle", busy, 0);
    issue(0, 3, "rst_iss");
    req(1, 1'b1);
    adv();
    settle();
    chk("rst_pre_stall", fence_stall, 1);
    req_valid = 1'b0; reset = 1'b1;
    adv();
    reset = 1'b0; req(0, 1'b0);
    settle();
    chk("rst_mid_valid", rsp_valid_out, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_stall", fence_stall, 0);
    chk("rst_mid_accept", req_ready, 1);
    adv();
    for (int k = 1; k < 5; k++) begin
      settle();
      chk("rst_cnt_cleared", req_ready, k < 4);
      adv();
    end
    req_valid = 1'b0;
    drain(0, 4, 16'h0D00);
    req(1, 1'b1);
    settle();
    chk("rsthold_fence", req_ready, 1);
    adv();
    req(0, 1'b0);
    settle();
    chk("rsthold_block", req_ready, 0);
    req_valid = 1'b0; reset = 1'b1;
    adv();
    reset = 1'b0; req(0, 1'b0);
    settle();
    chk("rsthold_accept", req_ready, 1);
    chk("rsthold_busy", busy, 0);
    adv();
    req_valid = 1'b0;
    drain(0, 1, 16'h0E00);
    chk("sb_left", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
